// File: rtl/cpu_core_pkg.sv
// Shared definitions for the execute stage of the MIPS core.
// Holds the pipeline bus widths and field offsets, the memory access size
// encodings, the one-hot ALU operation bit indices and the request FSM states.
package cpu_core_pkg;

  localparam int DS_TO_ES_BUS_WIDTH = 151;
  localparam int ES_TO_MS_BUS_WIDTH = 76;
  localparam int ALU_OP_WIDTH       = 12;

  // ds_to_es_bus field LSB positions:
  // {pc, alu_op, src1, src2, store_data, dest, reg_write, mem_read, mem_write, mem_size, mem_unsigned}
  localparam int DS_PC_LSB           = 119;
  localparam int DS_ALU_OP_LSB       = 107;
  localparam int DS_SRC1_LSB         = 75;
  localparam int DS_SRC2_LSB         = 43;
  localparam int DS_STORE_DATA_LSB   = 11;
  localparam int DS_DEST_LSB         = 6;
  localparam int DS_REG_WRITE_BIT    = 5;
  localparam int DS_MEM_READ_BIT     = 4;
  localparam int DS_MEM_WRITE_BIT    = 3;
  localparam int DS_MEM_SIZE_LSB     = 1;
  localparam int DS_MEM_UNSIGNED_BIT = 0;

  // es_to_ms_bus field LSB positions:
  // {pc, result, dest, reg_write, mem_read, mem_size, mem_unsigned, addr_low}
  localparam int ES_PC_LSB           = 44;
  localparam int ES_RESULT_LSB       = 12;
  localparam int ES_DEST_LSB         = 7;
  localparam int ES_REG_WRITE_BIT    = 6;
  localparam int ES_MEM_READ_BIT     = 5;
  localparam int ES_MEM_SIZE_LSB     = 3;
  localparam int ES_MEM_UNSIGNED_BIT = 2;
  localparam int ES_ADDR_LOW_LSB     = 0;

  // Access size; 2'b11 is treated as a word by the store formatter.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  // One-hot ALU operation bit indices.
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // Per-instruction data request state.
  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_SENT = 1'b1
  } req_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU of the MIPS core.
// Ports:
//   alu_op     one-hot operation select (bit indices from cpu_core_pkg)
//   alu_src1   operand 1 (shift amount in [4:0] for shifts)
//   alu_src2   operand 2 (value being shifted; immediate for lui)
//   alu_result result; zero when no operation bit is set
module alu
  import cpu_core_pkg::*;
(
  input  logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic [31:0]             alu_src1,
  input  logic [31:0]             alu_src2,
  output logic [31:0]             alu_result
);

  logic        sub_mode;
  logic [31:0] add_sub_result;
  logic        slt_result;
  logic        sltu_result;

  // One shared adder; subtraction is src1 + ~src2 + 1.
  assign sub_mode       = alu_op[ALU_SUB];
  assign add_sub_result = alu_src1 + (sub_mode ? ~alu_src2 : alu_src2) + {31'd0, sub_mode};
  assign slt_result     = $signed(alu_src1) < $signed(alu_src2);
  assign sltu_result    = alu_src1 < alu_src2;

  always_comb begin
    alu_result = '0;
    if (alu_op[ALU_ADD] | alu_op[ALU_SUB]) alu_result = alu_result | add_sub_result;
    if (alu_op[ALU_SLT])  alu_result = alu_result | {31'd0, slt_result};
    if (alu_op[ALU_SLTU]) alu_result = alu_result | {31'd0, sltu_result};
    if (alu_op[ALU_AND])  alu_result = alu_result | (alu_src1 & alu_src2);
    if (alu_op[ALU_NOR])  alu_result = alu_result | ~(alu_src1 | alu_src2);
    if (alu_op[ALU_OR])   alu_result = alu_result | (alu_src1 | alu_src2);
    if (alu_op[ALU_XOR])  alu_result = alu_result | (alu_src1 ^ alu_src2);
    if (alu_op[ALU_SLL])  alu_result = alu_result | (alu_src2 << alu_src1[4:0]);
    if (alu_op[ALU_SRL])  alu_result = alu_result | (alu_src2 >> alu_src1[4:0]);
    if (alu_op[ALU_SRA])  alu_result = alu_result | 32'($signed(alu_src2) >>> alu_src1[4:0]);
    if (alu_op[ALU_LUI])  alu_result = alu_result | {alu_src2[15:0], 16'd0};
  end

endmodule

// File: rtl/execute_stage_store_lane_format.sv
// Store lane formatter: places store data on the byte lanes of the 32-bit
// data bus and generates the matching byte write enables.
// Ports:
//   mem_size   access size (byte / half / word, 2'b11 as word)
//   addr_low   byte offset within the word
//   store_data register value to store (low bits used for byte/half)
//   wstrb      byte write enables
//   wdata      lane-replicated write data
module store_lane_format
  import cpu_core_pkg::*;
(
  input  logic [1:0]  mem_size,
  input  logic [1:0]  addr_low,
  input  logic [31:0] store_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata
);

  logic is_byte;
  logic is_half;

  assign is_byte = (mem_size == MEM_BYTE);
  assign is_half = (mem_size == MEM_HALF);

  // Data is replicated on every lane so the strobe alone selects the target
  // bytes; halfwords only look at addr_low[1] (alignment is checked upstream).
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign wstrb[gi] = is_byte ? (addr_low == LANE) :
                       is_half ? (addr_low[1] == LANE[1]) : 1'b1;
    assign wdata[8*gi +: 8] = is_byte ? store_data[7:0] :
                              is_half ? store_data[8*(gi%2) +: 8] :
                                        store_data[8*gi +: 8];
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the MIPS core: registers the decode-to-execute bus,
// drives the ALU, issues one data SRAM request per load/store, forwards the
// ALU result to decode and hands the instruction on to the memory stage.
// Ports:
//   clock, reset_n                   core clock, asynchronous active-low reset
//   flush                            squash the instruction held here
//   ds_to_es_valid/bus, es_allowin   decode-side handshake and payload
//   es_to_ms_valid/bus, ms_allowin   memory-side handshake and payload
//   data_req_*                       data SRAM request channel
//   es_forward_*                     forwarding / load-use information to decode
module execute_stage
  import cpu_core_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          ds_to_es_valid,
  output logic                          es_allowin,
  input  logic [DS_TO_ES_BUS_WIDTH-1:0] ds_to_es_bus,
  output logic                          es_to_ms_valid,
  input  logic                          ms_allowin,
  output logic [ES_TO_MS_BUS_WIDTH-1:0] es_to_ms_bus,
  output logic                          data_req_valid,
  input  logic                          data_req_ready,
  output logic                          data_req_write,
  output logic [31:0]                   data_req_addr,
  output logic [3:0]                    data_req_wstrb,
  output logic [31:0]                   data_req_wdata,
  output logic                          es_forward_valid,
  output logic [4:0]                    es_forward_dest,
  output logic [31:0]                   es_forward_data,
  output logic                          es_forward_is_load
);

  logic                          es_valid_q, es_valid_d;
  req_state_e                    req_state_q, req_state_d;
  logic [DS_TO_ES_BUS_WIDTH-1:0] ds_bus_q, ds_bus_d;

  logic [31:0]             es_pc;
  logic [ALU_OP_WIDTH-1:0] es_alu_op;
  logic [31:0]             es_src1;
  logic [31:0]             es_src2;
  logic [31:0]             es_store_data;
  logic [4:0]              es_dest;
  logic                    es_reg_write;
  logic                    es_mem_read;
  logic                    es_mem_write;
  logic [1:0]              es_mem_size;
  logic                    es_mem_unsigned;

  logic [31:0] alu_result;
  logic [3:0]  fmt_wstrb;
  logic [31:0] fmt_wdata;
  logic        es_mem_op;
  logic        req_sent;
  logic        req_fire;
  logic        es_ready_go;
  logic        es_leave;

  assign es_pc           = ds_bus_q[DS_PC_LSB +: 32];
  assign es_alu_op       = ds_bus_q[DS_ALU_OP_LSB +: ALU_OP_WIDTH];
  assign es_src1         = ds_bus_q[DS_SRC1_LSB +: 32];
  assign es_src2         = ds_bus_q[DS_SRC2_LSB +: 32];
  assign es_store_data   = ds_bus_q[DS_STORE_DATA_LSB +: 32];
  assign es_dest         = ds_bus_q[DS_DEST_LSB +: 5];
  assign es_reg_write    = ds_bus_q[DS_REG_WRITE_BIT];
  assign es_mem_read     = ds_bus_q[DS_MEM_READ_BIT];
  assign es_mem_write    = ds_bus_q[DS_MEM_WRITE_BIT];
  assign es_mem_size     = ds_bus_q[DS_MEM_SIZE_LSB +: 2];
  assign es_mem_unsigned = ds_bus_q[DS_MEM_UNSIGNED_BIT];

  alu u_alu (
    .alu_op     (es_alu_op),
    .alu_src1   (es_src1),
    .alu_src2   (es_src2),
    .alu_result (alu_result)
  );

  store_lane_format u_store_lane_format (
    .mem_size   (es_mem_size),
    .addr_low   (alu_result[1:0]),
    .store_data (es_store_data),
    .wstrb      (fmt_wstrb),
    .wdata      (fmt_wdata)
  );

  // Once the request has been accepted it is never re-presented; the stage
  // then only waits on ms_allowin. flush masks the request in the same cycle.
  assign es_mem_op      = es_mem_read | es_mem_write;
  assign req_sent       = (req_state_q == REQ_SENT);
  assign data_req_valid = es_valid_q & es_mem_op & ~req_sent & ~flush;
  assign req_fire       = data_req_valid & data_req_ready;
  assign es_ready_go    = es_mem_op ? (req_sent | req_fire) : 1'b1;
  assign es_allowin     = ~es_valid_q | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid_q & es_ready_go & ~flush;
  assign es_leave       = es_to_ms_valid & ms_allowin;

  always_comb begin
    es_valid_d = es_valid_q;
    if (flush) begin
      es_valid_d = 1'b0;
    end else if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
    end

    ds_bus_d = ds_bus_q;
    if (ds_to_es_valid && es_allowin) begin
      ds_bus_d = ds_to_es_bus;
    end

    // A handshake in the cycle the instruction leaves needs no memory of it.
    req_state_d = req_state_q;
    if (flush || es_leave) begin
      req_state_d = REQ_IDLE;
    end else if (req_fire) begin
      req_state_d = REQ_SENT;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      es_valid_q  <= 1'b0;
      req_state_q <= REQ_IDLE;
      ds_bus_q    <= '0;
    end else begin
      es_valid_q  <= es_valid_d;
      req_state_q <= req_state_d;
      ds_bus_q    <= ds_bus_d;
    end
  end

  assign data_req_write = es_mem_write;
  assign data_req_addr  = {alu_result[31:2], 2'b00};
  assign data_req_wstrb = es_mem_write ? fmt_wstrb : 4'b0000;
  assign data_req_wdata = fmt_wdata;

  assign es_to_ms_bus = {es_pc, alu_result, es_dest, es_reg_write, es_mem_read,
                         es_mem_size, es_mem_unsigned, alu_result[1:0]};

  assign es_forward_valid   = es_valid_q & es_reg_write & (es_dest != 5'd0);
  assign es_forward_dest    = es_dest;
  assign es_forward_data    = alu_result;
  assign es_forward_is_load = es_valid_q & es_mem_read;

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed scenarios plus a short ALU loop.
// Expected memory-stage bus values and data requests are queued when an
// instruction is accepted and compared when the DUT presents them.
module tb_execute_stage;
  import cpu_core_pkg::*;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         ds_to_es_valid = 1'b0;
  logic         ms_allowin = 1'b1;
  logic         data_req_ready = 1'b0;
  logic [150:0] ds_to_es_bus = '0;

  logic         es_allowin, es_to_ms_valid, data_req_valid, data_req_write;
  logic [75:0]  es_to_ms_bus;
  logic [31:0]  data_req_addr, data_req_wdata, es_forward_data;
  logic [3:0]   data_req_wstrb;
  logic         es_forward_valid, es_forward_is_load;
  logic [4:0]   es_forward_dest;

  execute_stage dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .flush              (flush),
    .ds_to_es_valid     (ds_to_es_valid),
    .es_allowin         (es_allowin),
    .ds_to_es_bus       (ds_to_es_bus),
    .es_to_ms_valid     (es_to_ms_valid),
    .ms_allowin         (ms_allowin),
    .es_to_ms_bus       (es_to_ms_bus),
    .data_req_valid     (data_req_valid),
    .data_req_ready     (data_req_ready),
    .data_req_write     (data_req_write),
    .data_req_addr      (data_req_addr),
    .data_req_wstrb     (data_req_wstrb),
    .data_req_wdata     (data_req_wdata),
    .es_forward_valid   (es_forward_valid),
    .es_forward_dest    (es_forward_dest),
    .es_forward_data    (es_forward_data),
    .es_forward_is_load (es_forward_is_load)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  int assert_cnt = 0;
  int fail_cnt = 0;
  int hs_cnt = 0;
  int wr_cnt = 0;
  logic [75:0] ms_q[$];
  req_t        req_q[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_AND:  return a & b;
      ALU_NOR:  return ~(a | b);
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [150:0] mk_ds(input logic [31:0] pc, input int op, input logic [31:0] s1,
                                         input logic [31:0] s2, input logic [31:0] sd, input logic [4:0] dest,
                                         input logic rw, input logic mr, input logic mw, input logic [1:0] size);
    logic [11:0] onehot;
    onehot = 12'b1 << op;
    return {pc, onehot, s1, s2, sd, dest, rw, mr, mw, size, 1'b0};
  endfunction

  function automatic logic [75:0] mk_ms(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                                        input logic rw, input logic mr, input logic [1:0] size);
    return {pc, res, dest, rw, mr, size, 1'b0, res[1:0]};
  endfunction

  // Drive one instruction and wait (bounded) for the stage to accept it.
  task automatic issue(input logic [150:0] bus, input bit keep, input logic [75:0] ms_exp,
                       input bit has_req, input req_t rq);
    int  n;
    bit  acc;
    n = 0;
    acc = 1'b0;
    ds_to_es_bus = bus;
    ds_to_es_valid = 1'b1;
    while (!acc) begin
      @(negedge clock);
      acc = es_allowin;
      if (acc && keep) begin
        ms_q.push_back(ms_exp);
        if (has_req) req_q.push_back(rq);
      end
      @(posedge clock);
      #1;
      n++;
      if (!acc && n >= 20) begin
        check_eq("accept_timeout", 128'(n), 128'(0));
        break;
      end
    end
    ds_to_es_valid = 1'b0;
  endtask

  task automatic issue_alu(input logic [31:0] pc, input int op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] dest);
    logic [31:0] r;
    r = ref_alu(op, a, b);
    issue(mk_ds(pc, op, a, b, 32'd0, dest, 1'b1, 1'b0, 1'b0, 2'b10), 1'b1,
          mk_ms(pc, r, dest, 1'b1, 1'b0, 2'b10), 1'b0, '0);
  endtask

  task automatic issue_mem(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] sd, input logic [4:0] dest, input logic mr, input logic mw,
                           input logic [1:0] size, input logic [3:0] strb, input logic [31:0] wd, input bit keep);
    logic [31:0] r;
    req_t        rq;
    r = a + b;
    rq.wr = mw;
    rq.addr = {r[31:2], 2'b00};
    rq.strb = strb;
    rq.wdata = wd;
    issue(mk_ds(pc, ALU_ADD, a, b, sd, dest, mr, mr, mw, size), keep,
          mk_ms(pc, r, dest, mr, mr, size), 1'b1, rq);
  endtask

  // Memory-stage and data-request monitors, sampled on the falling edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (es_to_ms_valid && ms_allowin) begin
        if (ms_q.size() == 0) begin
          check_eq("ms_unexpected", 128'(ms_q.size()), 128'(1));
        end else begin
          logic [75:0] e;
          e = ms_q.pop_front();
          $display("ms  txn pc=%h result=%h dest=%0d", es_to_ms_bus[ES_PC_LSB +: 32],
                   es_to_ms_bus[ES_RESULT_LSB +: 32], es_to_ms_bus[ES_DEST_LSB +: 5]);
          check_eq("ms_bus", 128'(es_to_ms_bus), 128'(e));
        end
      end
      if (data_req_valid && data_req_ready) begin
        hs_cnt++;
        if (data_req_write) wr_cnt++;
        $display("req txn wr=%0d addr=%h strb=%b wdata=%h", data_req_write, data_req_addr,
                 data_req_wstrb, data_req_wdata);
        if (req_q.size() == 0) begin
          check_eq("req_unexpected", 128'(req_q.size()), 128'(1));
        end else begin
          req_t e;
          e = req_q.pop_front();
          check_eq("req_write", 128'(data_req_write), 128'(e.wr));
          check_eq("req_addr", 128'(data_req_addr), 128'(e.addr));
          check_eq("req_wstrb", 128'(data_req_wstrb), 128'(e.strb));
          if (e.wr) check_eq("req_wdata", 128'(data_req_wdata), 128'(e.wdata));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ops[8];
    int hs0;
    int wr0;
    ops = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_NOR, ALU_OR, ALU_XOR};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_es_to_ms_valid", 128'(es_to_ms_valid), 128'(0));
    check_eq("rst_data_req_valid", 128'(data_req_valid), 128'(0));
    check_eq("rst_fwd_valid", 128'(es_forward_valid), 128'(0));
    check_eq("rst_allowin", 128'(es_allowin), 128'(1));
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Plain add, one cycle in stage
    ms_allowin = 1'b1;
    data_req_ready = 1'b1;
    issue_alu(32'h100, ALU_ADD, 32'd5, 32'd7, 5'd3);
    check_eq("add_es_to_ms_valid", 128'(es_to_ms_valid), 128'(1));
    check_eq("add_fwd_valid", 128'(es_forward_valid), 128'(1));
    check_eq("add_fwd_dest", 128'(es_forward_dest), 128'(3));
    check_eq("add_fwd_data", 128'(es_forward_data), 128'(12));
    check_eq("add_no_req", 128'(data_req_valid), 128'(0));

    // Back-to-back ALU operations with random operands
    for (int i = 0; i < 8; i++) begin
      issue_alu(32'h200 + 32'(4 * i), ops[i], $urandom, $urandom, 5'(i + 1));
    end
    issue_alu(32'h240, ALU_OR, 32'h0F0F_0000, 32'h0000_00F0, 5'd0);
    check_eq("dest0_fwd_valid", 128'(es_forward_valid), 128'(0));

    // Byte and halfword stores
    issue_mem(32'h300, 32'h1000, 32'd3, 32'h1234_56AB, 5'd0, 1'b0, 1'b1, 2'b00,
              4'b1000, 32'hABAB_ABAB, 1'b1);
    check_eq("sb_req_valid", 128'(data_req_valid), 128'(1));
    check_eq("sb_addr", 128'(data_req_addr), 128'(32'h1000));
    check_eq("sb_wstrb", 128'(data_req_wstrb), 128'(4'b1000));
    check_eq("sb_wdata", 128'(data_req_wdata), 128'(32'hABAB_ABAB));
    check_eq("sb_write", 128'(data_req_write), 128'(1));
    issue_mem(32'h304, 32'h1000, 32'd2, 32'h1234_56AB, 5'd0, 1'b0, 1'b1, 2'b01,
              4'b1100, 32'h56AB_56AB, 1'b1);
    check_eq("sh_wstrb", 128'(data_req_wstrb), 128'(4'b1100));
    check_eq("sh_wdata", 128'(data_req_wdata), 128'(32'h56AB_56AB));
    @(posedge clock);
    #1;

    // Load waiting three cycles on data_req_ready
    data_req_ready = 1'b0;
    hs0 = hs_cnt;
    issue_mem(32'h400, 32'h2000, 32'd4, 32'd0, 5'd8, 1'b1, 1'b0, 2'b10, 4'b0000, 32'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check_eq("lw_wait_req_valid", 128'(data_req_valid), 128'(1));
      check_eq("lw_wait_allowin", 128'(es_allowin), 128'(0));
      check_eq("lw_wait_is_load", 128'(es_forward_is_load), 128'(1));
      check_eq("lw_wait_ms_valid", 128'(es_to_ms_valid), 128'(0));
      @(posedge clock);
      #1;
    end
    data_req_ready = 1'b1;
    #1;
    check_eq("lw_ready_ms_valid", 128'(es_to_ms_valid), 128'(1));
    @(posedge clock);
    #1;
    data_req_ready = 1'b0;
    check_eq("lw_one_handshake", 128'(hs_cnt - hs0), 128'(1));
    check_eq("lw_gone_req_valid", 128'(data_req_valid), 128'(0));

    // Load accepted while the memory stage stalls
    ms_allowin = 1'b0;
    data_req_ready = 1'b1;
    hs0 = hs_cnt;
    issue_mem(32'h500, 32'h3000, 32'd8, 32'd0, 5'd9, 1'b1, 1'b0, 2'b10, 4'b0000, 32'd0, 1'b1);
    check_eq("stall_req_valid", 128'(data_req_valid), 128'(1));
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("stall_no_rereq", 128'(data_req_valid), 128'(0));
      check_eq("stall_allowin", 128'(es_allowin), 128'(0));
      check_eq("stall_ms_valid", 128'(es_to_ms_valid), 128'(1));
      @(posedge clock);
      #1;
    end
    ms_allowin = 1'b1;
    #1;
    check_eq("stall_release_allowin", 128'(es_allowin), 128'(1));
    @(posedge clock);
    #1;
    check_eq("stall_one_handshake", 128'(hs_cnt - hs0), 128'(1));
    issue_mem(32'h504, 32'h3000, 32'd12, 32'd0, 5'd10, 1'b1, 1'b0, 2'b10, 4'b0000, 32'd0, 1'b1);
    check_eq("next_load_req_valid", 128'(data_req_valid), 128'(1));
    @(posedge clock);
    #1;
    check_eq("next_load_handshake", 128'(hs_cnt - hs0), 128'(2));

    // Flush while a store waits on the SRAM
    data_req_ready = 1'b0;
    wr0 = wr_cnt;
    issue_mem(32'h600, 32'h4000, 32'd0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 2'b10,
              4'b1111, 32'hDEAD_BEEF, 1'b0);
    check_eq("flush_pre_req_valid", 128'(data_req_valid), 128'(1));
    flush = 1'b1;
    data_req_ready = 1'b1;
    #1;
    check_eq("flush_req_masked", 128'(data_req_valid), 128'(0));
    check_eq("flush_ms_masked", 128'(es_to_ms_valid), 128'(0));
    @(posedge clock);
    #1;
    flush = 1'b0;
    #1;
    check_eq("flush_after_req_valid", 128'(data_req_valid), 128'(0));
    check_eq("flush_after_allowin", 128'(es_allowin), 128'(1));
    check_eq("flush_no_write", 128'(wr_cnt - wr0), 128'(0));

    // Flush drops an instruction offered in the same cycle
    ds_to_es_bus = mk_ds(32'h680, ALU_ADD, 32'd1, 32'd1, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 2'b10);
    ds_to_es_valid = 1'b1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    ds_to_es_valid = 1'b0;
    flush = 1'b0;
    #1;
    check_eq("flush_drop_ms_valid", 128'(es_to_ms_valid), 128'(0));
    check_eq("flush_drop_fwd_valid", 128'(es_forward_valid), 128'(0));

    // Asynchronous reset in the middle of a request
    data_req_ready = 1'b0;
    issue_mem(32'h700, 32'h5000, 32'd4, 32'd0, 5'd11, 1'b1, 1'b0, 2'b10, 4'b0000, 32'd0, 1'b0);
    check_eq("mid_pre_req_valid", 128'(data_req_valid), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_req_valid", 128'(data_req_valid), 128'(0));
    check_eq("mid_rst_ms_valid", 128'(es_to_ms_valid), 128'(0));
    check_eq("mid_rst_fwd_valid", 128'(es_forward_valid), 128'(0));
    check_eq("mid_rst_is_load", 128'(es_forward_is_load), 128'(0));
    check_eq("mid_rst_allowin", 128'(es_allowin), 128'(1));
    check_eq("mid_rst_ms_bus", 128'(es_to_ms_bus), 128'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    data_req_ready = 1'b1;
    issue_alu(32'h800, ALU_ADD, 32'd20, 32'd22, 5'd5);
    check_eq("post_rst_ms_valid", 128'(es_to_ms_valid), 128'(1));
    check_eq("post_rst_fwd_data", 128'(es_forward_data), 128'(42));
    repeat (3) @(posedge clock);
    #1;

    check_eq("ms_q_drained", 128'(ms_q.size()), 128'(0));
    check_eq("req_q_drained", 128'(req_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline execute stage of the MIPS core. Sits between decode and memory stages.
- Registers the decode-to-execute bus and drives the existing combinational ALU.
- Issues load/store requests to the data SRAM interface, provides a forwarding/load-use bus back to decode, and hands results to the memory stage.
- Uses valid/allowin pipeline handshakes on both sides.

Parameters:
DS_TO_ES_BUS_WIDTH, 151, decode-to-execute bus width (fields below).
ES_TO_MS_BUS_WIDTH, 76, execute-to-memory bus width (fields below).

Ports:
clock  input  1  single core clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
flush  input  1  squash the instruction held in this stage.
ds_to_es_valid  input  1  decode offers an instruction.
es_allowin  output  1  this stage can accept an instruction this cycle.
ds_to_es_bus  input  DS_TO_ES_BUS_WIDTH  {pc[32], alu_op[12], src1[32], src2[32], store_data[32], dest[5], reg_write, mem_read, mem_write, mem_size[2], mem_unsigned}.
es_to_ms_valid  output  1  instruction presented to the memory stage.
ms_allowin  input  1  memory stage can accept.
es_to_ms_bus  output  ES_TO_MS_BUS_WIDTH  {pc, result[32], dest, reg_write, mem_read, mem_size, mem_unsigned, addr_low[2]}.
data_req_valid  output  1  data SRAM request valid.
data_req_ready  input  1  data SRAM accepts the request.
data_req_write  output  1  1 = store, 0 = load.
data_req_addr  output  32  word-aligned address.
data_req_wstrb  output  4  byte write enables (0000 for loads).
data_req_wdata  output  32  store data, lane-replicated.
es_forward_valid  output  1  stage holds a register-writing instruction.
es_forward_dest  output  5  destination register.
es_forward_data  output  32  ALU result.
es_forward_is_load  output  1  forwarded value not yet available (load-use stall).

Behaviour:
- Reset (asynchronous, reset_n low):
  - es_valid and req_sent clear; all bus registers clear to 0.
  - Resulting outputs: es_to_ms_valid=0, data_req_valid=0, es_forward_valid=0, es_allowin=1.
- Handshake:
  - es_allowin = !es_valid | (es_ready_go & ms_allowin).
  - When es_allowin: es_valid <= ds_to_es_valid. The bus is latched only when ds_to_es_valid & es_allowin.
  - flush has priority and clears es_valid next cycle, regardless of allowin.
- es_to_ms_valid = es_valid & es_ready_go & !flush.
- Latency:
  - Non-memory instruction: es_ready_go=1, one cycle in stage.
  - Memory instruction: es_ready_go = req_sent | (data_req_valid & data_req_ready).
- Request FSM, per instruction (req_sent: IDLE/SENT):
  - data_req_valid = es_valid & (mem_read | mem_write) & !req_sent & !flush.
  - req_sent sets on a request handshake when the instruction does not leave the stage that cycle.
  - req_sent clears when the instruction leaves (es_to_ms_valid & ms_allowin) or on flush.
  - At most one request is issued per instruction, even while ms_allowin is low.
  - data_req_valid, once high, holds with stable addr/wstrb/wdata until data_req_ready.
- ALU result:
  - result = alu(alu_op, src1, src2). The address is result; the ALU performs an add for memory ops.
  - data_req_addr = {result[31:2], 2'b00}; addr_low = result[1:0].
- Store formatting, by mem_size (00 byte, 01 half, 10 word, 11 treated as word):
  - Byte: wstrb = 0001 << addr_low; wdata = store_data[7:0] replicated x4.
  - Half: wstrb = addr_low[1] ? 1100 : 0011; wdata = store_data[15:0] replicated x2.
  - Word: wstrb = 1111; wdata = store_data.
  - Misalignment is checked upstream; here half uses addr_low[1] only and word ignores addr_low.
- Forwarding:
  - es_forward_valid = es_valid & reg_write & (dest != 0).
  - es_forward_is_load = es_valid & mem_read.
  - es_forward_data = result.
- Simultaneous events:
  - Flush in the same cycle as data_req_ready: no request is presented, because valid is gated by flush.
  - Flush with ds_to_es_valid & es_allowin: the new instruction is dropped.
  - Reset mid-request: the request is abandoned immediately.

Decomposition:
- Package cpu_core_pkg holds:
  - bus widths and field offsets for ds_to_es/es_to_ms;
  - mem_size encodings (MEM_BYTE, MEM_HALF, MEM_WORD);
  - ALU operation bit indices (ALU_ADD..ALU_LUI, 12 one-hot).
- Sub-modules:
  - existing alu, instantiated combinationally;
  - one new sub-module, store_lane_format (mem_size, addr_low, store_data -> wstrb, wdata).

Test Plan:
- Reset, then add with src1=5, src2=7, dest=3, ms_allowin=1: next cycle es_to_ms_valid=1, result=12, es_forward_valid=1, dest=3; data_req_valid stays 0.
- sb with address 0x00001003, store_data=0x123456AB: data_req_addr=0x00001000, wstrb=1000, wdata=0xABABABAB, write=1; sh at 0x1002 gives wstrb=1100, wdata=0x56AB56AB.
- lw with data_req_ready low for 3 cycles: data_req_valid held 3 cycles, es_allowin=0, es_forward_is_load=1; ready on cycle 4 gives exactly one handshake, then es_to_ms_valid=1.
- Load accepted while ms_allowin=0 for 2 cycles: data_req_valid drops after the handshake and is never reasserted; the instruction passes when ms_allowin=1, and req_sent clears.
- flush asserted while a store waits on data_req_ready=0: data_req_valid=0 that cycle, es_valid=0 next, no write ever issued.
- reset_n pulsed low mid-request: all outputs return to reset values asynchronously; a new add issues normally afterwards.
